cdcm8_tx_sequencer: RTL and testbench

//  Link-bring-up controller for the CDCM8 8:1 serializer TX on the clkDivIn domain.
//  - Holds the serializer in ioReset, then releases it and waits for its scanFinished.
//  - Sends a training word for a fixed count, then opens a valid/ready path for user words.
//  - Sends the idle word when there is no user data.
//  - Retries a stalled bring-up a bounded number of times; restarts on request.

---
 rtl/cdcm8_tx_sequencer_pkg.sv | 25 ++
 rtl/cdcm8_tx_sequencer_seq_timer.sv | 38 +++
 rtl/cdcm8_tx_sequencer.sv | 130 +++++++++++++
 tb/tb_cdcm8_tx_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cdcm8_tx_sequencer_pkg.sv
// Shared types and defaults for the CDCM8 TX bring-up sequencer.
// Holds the state encoding, the default words and the counter-width helper.
package cdcm8_tx_seq_pkg;

  typedef enum logic [2:0] {
    RST_HOLD  = 3'd0,
    SCAN_WAIT = 3'd1,
    TRAIN     = 3'd2,
    ACTIVE    = 3'd3,
    FAILED    = 3'd4
  } seq_state_e;

  localparam logic [7:0] TRAIN_PATTERN = 8'hF0;
  localparam logic [7:0] IDLE_PATTERN  = 8'h3C;

  // Wide enough for the longest phase with one spare bit, so the count never wraps.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/cdcm8_tx_sequencer_seq_timer.sv
// Saturating up-counter with clear, load and a terminal-count compare.
// Counts every cycle; the terminal value is supplied by the owning FSM.
module seq_timer #(
  parameter int kW = 11
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          clr_i,
  input  logic          load_i,
  input  logic [kW-1:0] load_value_i,
  input  logic [kW-1:0] tc_value_i,
  output logic [kW-1:0] count_o,
  output logic          tc_o
);

  logic [kW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)
      count_d = '0;
    else if (load_i)
      count_d = load_value_i;
    else if (count_q != '1)
      count_d = count_q + kW'(1);
  end

  always_ff @(posedge clk) begin
    if (srst)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == tc_value_i);

endmodule

// File: rtl/cdcm8_tx_sequencer.sv
// Link bring-up controller for the CDCM8 8:1 serializer transmit side.
// Resets the serializer, waits for its scan, trains, then passes user words.
module cdcm8_tx_sequencer
  import cdcm8_tx_seq_pkg::*;
#(
  parameter int               kDevW         = 8,
  parameter int               kRstCycles    = 16,
  parameter int               kScanTimeout  = 1024,
  parameter int               kTrainCycles  = 64,
  parameter int               kMaxRetry     = 3,
  parameter logic [kDevW-1:0] kTrainPattern = kDevW'(TRAIN_PATTERN),
  parameter logic [kDevW-1:0] kIdlePattern  = kDevW'(IDLE_PATTERN)
) (
  input  logic             clkDivIn,
  input  logic             rst,
  input  logic             restartReq,
  input  logic [kDevW-1:0] dataIn,
  input  logic             validIn,
  output logic             readyOut,
  output logic [kDevW-1:0] dOutToTx,
  output logic             ioResetOut,
  input  logic             scanFinishedIn,
  output logic             txReady,
  output logic             errorOut,
  output logic [1:0]       retryCount
);

  localparam int         kCntW     = cnt_width(kRstCycles, kScanTimeout, kTrainCycles);
  localparam logic [1:0] kRetryMax = 2'(kMaxRetry);

  seq_state_e       state_q, state_d;
  logic [1:0]       retry_q, retry_d, retry_inc;
  logic [kDevW-1:0] dout_q, dout_d;
  logic             io_reset_q, io_reset_d;
  logic             tx_ready_q, tx_ready_d;
  logic             error_q, error_d;

  logic [kCntW-1:0] count, tc_value;
  logic             tc_hit, timer_clr, accept;

  // Restart wins over a handshake, so the word offered in that cycle is refused.
  assign readyOut  = (state_q == ACTIVE) && !restartReq && !rst;
  assign accept    = readyOut && validIn;
  assign retry_inc = (retry_q == kRetryMax) ? retry_q : retry_q + 2'd1;
  assign timer_clr = restartReq || (state_d != state_q);

  always_comb begin
    tc_value = '1;
    case (state_q)
      RST_HOLD:  tc_value = kCntW'(kRstCycles - 1);
      SCAN_WAIT: tc_value = kCntW'(kScanTimeout - 1);
      TRAIN:     tc_value = kCntW'(kTrainCycles - 1);
      default:   tc_value = '1;
    endcase
  end

  seq_timer #(.kW(kCntW)) u_timer (
    .clk          (clkDivIn),
    .srst         (rst),
    .clr_i        (timer_clr),
    .load_i       (1'b0),
    .load_value_i ('0),
    .tc_value_i   (tc_value),
    .count_o      (count),
    .tc_o         (tc_hit)
  );

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    if (restartReq) begin
      state_d = RST_HOLD;
      retry_d = '0;
    end else begin
      case (state_q)
        RST_HOLD:  if (tc_hit) state_d = SCAN_WAIT;
        SCAN_WAIT: begin
          // The scan flag is stale on the entry cycle, so it is only trusted from count 1.
          if (scanFinishedIn && (count != '0)) begin
            state_d = TRAIN;
          end else if (tc_hit) begin
            retry_d = retry_inc;
            state_d = (retry_inc < kRetryMax) ? RST_HOLD : FAILED;
          end
        end
        TRAIN: begin
          if (!scanFinishedIn)
            state_d = RST_HOLD;
          else if (tc_hit)
            state_d = ACTIVE;
        end
        ACTIVE:    if (!scanFinishedIn) state_d = RST_HOLD;
        default:   state_d = state_q;
      endcase
    end

    io_reset_d = (state_d == RST_HOLD) || (state_d == FAILED);
    tx_ready_d = (state_d == ACTIVE);
    error_d    = (state_d == FAILED);
    if (state_d == ACTIVE)
      dout_d = accept ? dataIn : kIdlePattern;
    else
      dout_d = kTrainPattern;
  end

  always_ff @(posedge clkDivIn) begin
    if (rst) begin
      state_q    <= RST_HOLD;
      retry_q    <= '0;
      dout_q     <= kTrainPattern;
      io_reset_q <= 1'b1;
      tx_ready_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      retry_q    <= retry_d;
      dout_q     <= dout_d;
      io_reset_q <= io_reset_d;
      tx_ready_q <= tx_ready_d;
      error_q    <= error_d;
    end
  end

  assign dOutToTx   = dout_q;
  assign ioResetOut = io_reset_q;
  assign txReady    = tx_ready_q;
  assign errorOut   = error_q;
  assign retryCount = retry_q;

endmodule

// File: tb/tb_cdcm8_tx_sequencer.sv
// Randomized bench for cdcm8_tx_sequencer against a phase/age reference model.
// Every cycle all registered outputs and readyOut are compared to the model.
module tb_cdcm8_tx_sequencer;

  localparam int P_HOLD = 0, P_SCAN = 1, P_TRAIN = 2, P_LIVE = 3, P_DEAD = 4;
  localparam int HOLD_LEN = 16, SCAN_LEN = 1024, TRAIN_LEN = 64, MAX_RETRY = 3;
  localparam logic [7:0] TRAIN_W = 8'hF0;
  localparam logic [7:0] IDLE_W  = 8'h3C;

  logic       clkDivIn = 1'b0;
  logic       rst = 1'b1;
  logic       restartReq = 1'b0;
  logic [7:0] dataIn = 8'h00;
  logic       validIn = 1'b0;
  logic       scanFinishedIn = 1'b0;
  logic       readyOut;
  logic [7:0] dOutToTx;
  logic       ioResetOut;
  logic       txReady;
  logic       errorOut;
  logic [1:0] retryCount;

  int n_checks = 0;
  int n_pass   = 0;

  int         m_phase   = P_HOLD;
  int         m_age     = 0;
  int         m_retries = 0;
  logic [7:0] m_word    = TRAIN_W;

  int         retry_seen[$];
  logic [7:0] words [3];

  cdcm8_tx_sequencer dut (
    .clkDivIn       (clkDivIn),
    .rst            (rst),
    .restartReq     (restartReq),
    .dataIn         (dataIn),
    .validIn        (validIn),
    .readyOut       (readyOut),
    .dOutToTx       (dOutToTx),
    .ioResetOut     (ioResetOut),
    .scanFinishedIn (scanFinishedIn),
    .txReady        (txReady),
    .errorOut       (errorOut),
    .retryCount     (retryCount)
  );

  always #5 clkDivIn = ~clkDivIn;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Phases last a fixed number of cycles; age counts cycles already spent in the phase.
  task automatic model_advance();
    int nxt;
    bit acc;
    acc = (m_phase == P_LIVE) && validIn && !restartReq && !rst;
    if (acc) $display("accept word %02h at %0t", dataIn, $time);
    nxt = m_phase;
    if (rst || restartReq) begin
      nxt = P_HOLD;
      m_retries = 0;
    end else begin
      case (m_phase)
        P_HOLD:  if (m_age + 1 >= HOLD_LEN) nxt = P_SCAN;
        P_SCAN: begin
          if (m_age > 0 && scanFinishedIn) nxt = P_TRAIN;
          else if (m_age + 1 >= SCAN_LEN) begin
            if (m_retries < MAX_RETRY) m_retries++;
            nxt = (m_retries < MAX_RETRY) ? P_HOLD : P_DEAD;
          end
        end
        P_TRAIN: begin
          if (!scanFinishedIn) nxt = P_HOLD;
          else if (m_age + 1 >= TRAIN_LEN) nxt = P_LIVE;
        end
        P_LIVE:  if (!scanFinishedIn) nxt = P_HOLD;
        default: nxt = m_phase;
      endcase
    end
    m_age   = (nxt != m_phase || rst || restartReq) ? 0 : m_age + 1;
    m_word  = (nxt == P_LIVE) ? (acc ? dataIn : IDLE_W) : TRAIN_W;
    m_phase = nxt;
  endtask

  // Inputs are already driven; check readyOut, advance model, clock, check registers.
  task automatic step();
    #1;
    check_eq("readyOut", {31'd0, readyOut},
             {31'd0, (m_phase == P_LIVE) && !restartReq && !rst});
    model_advance();
    @(posedge clkDivIn);
    #1;
    check_eq("ioResetOut", {31'd0, ioResetOut}, {31'd0, (m_phase == P_HOLD) || (m_phase == P_DEAD)});
    check_eq("txReady",    {31'd0, txReady},    {31'd0, m_phase == P_LIVE});
    check_eq("errorOut",   {31'd0, errorOut},   {31'd0, m_phase == P_DEAD});
    check_eq("dOutToTx",   {24'd0, dOutToTx},   {24'd0, m_word});
    check_eq("retryCount", {30'd0, retryCount}, m_retries);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, hold_n, last;
    @(posedge clkDivIn);
    #1;

    // 1: reset and bring-up with the scan flag following ioResetOut
    rst = 1'b1;
    repeat (3) begin scanFinishedIn = !ioResetOut; step(); end
    check_eq("rst_ioReset", {31'd0, ioResetOut}, 32'd1);
    check_eq("rst_dout", {24'd0, dOutToTx}, {24'd0, TRAIN_W});
    rst = 1'b0;
    n = 0; hold_n = 0;
    while (!txReady && n < 300) begin
      if (ioResetOut) hold_n++;
      scanFinishedIn = !ioResetOut;
      step();
      n++;
    end
    check_eq("hold_cycles", hold_n, HOLD_LEN);
    check_eq("bringup_cycles", n, HOLD_LEN + 2 + TRAIN_LEN);

    // 2: back-to-back user words, then idle, then random traffic
    words[0] = 8'hA5; words[1] = 8'h5A; words[2] = 8'h01;
    for (int i = 0; i < 3; i++) begin
      validIn = 1'b1; dataIn = words[i]; scanFinishedIn = !ioResetOut;
      step();
      check_eq("word_seq", {24'd0, dOutToTx}, {24'd0, words[i]});
    end
    validIn = 1'b0;
    step();
    check_eq("idle_word", {24'd0, dOutToTx}, {24'd0, IDLE_W});
    for (int i = 0; i < 60; i++) begin
      validIn = 1'($urandom_range(0, 1)); dataIn = 8'($urandom);
      scanFinishedIn = !ioResetOut;
      step();
    end
    validIn = 1'b0;

    // 3: scan never completes, three timed-out attempts then FAILED
    scanFinishedIn = 1'b0;
    n = 0; last = retryCount;
    while (!errorOut && n < 4000) begin
      step();
      n++;
      if (retryCount != last) begin retry_seen.push_back(retryCount); last = retryCount; end
    end
    check_eq("fail_cycles", n, 1 + MAX_RETRY * (HOLD_LEN + SCAN_LEN));
    check_eq("retry_steps", retry_seen.size(), 3);
    if (retry_seen.size() == 3) begin
      check_eq("retry_1", retry_seen[0], 1);
      check_eq("retry_2", retry_seen[1], 2);
      check_eq("retry_3", retry_seen[2], 3);
    end
    for (int i = 0; i < 20; i++) begin
      validIn = 1'($urandom_range(0, 1)); dataIn = 8'($urandom);
      scanFinishedIn = 1'($urandom_range(0, 1));
      step();
    end
    check_eq("failed_ioReset", {31'd0, ioResetOut}, 32'd1);

    // 4: restart from FAILED with a working scan flag
    validIn = 1'b0; restartReq = 1'b1; scanFinishedIn = !ioResetOut;
    step();
    restartReq = 1'b0;
    check_eq("restart_retry", {30'd0, retryCount}, 32'd0);
    check_eq("restart_error", {31'd0, errorOut}, 32'd0);
    n = 0;
    while (!txReady && n < 300) begin scanFinishedIn = !ioResetOut; step(); n++; end
    check_eq("rebringup_cycles", n, HOLD_LEN + 2 + TRAIN_LEN);

    // 5: restart while a word is offered in ACTIVE
    validIn = 1'b1; dataIn = 8'($urandom); restartReq = 1'b1; scanFinishedIn = 1'b1;
    #1;
    check_eq("restart_readyOut", {31'd0, readyOut}, 32'd0);
    step();
    restartReq = 1'b0; validIn = 1'b0;
    check_eq("restart_io", {31'd0, ioResetOut}, 32'd1);
    check_eq("restart_txReady", {31'd0, txReady}, 32'd0);

    // 6: one failed attempt, then scan arriving on the timeout cycle, then a drop in TRAIN
    scanFinishedIn = 1'b0;
    repeat (HOLD_LEN + SCAN_LEN) step();
    check_eq("attempt_retry", {30'd0, retryCount}, 32'd1);
    repeat (HOLD_LEN + SCAN_LEN - 1) step();
    scanFinishedIn = 1'b1;
    step();
    check_eq("race_io", {31'd0, ioResetOut}, 32'd0);
    check_eq("race_retry", {30'd0, retryCount}, 32'd1);
    repeat (10) step();
    scanFinishedIn = 1'b0;
    step();
    check_eq("drop_io", {31'd0, ioResetOut}, 32'd1);
    check_eq("drop_retry", {30'd0, retryCount}, 32'd1);

    // 7: random mix of traffic, restarts, scan drops and resets
    for (int i = 0; i < 600; i++) begin
      rst        = ($urandom_range(0, 199) == 0);
      restartReq = ($urandom_range(0, 99) == 0);
      scanFinishedIn = ($urandom_range(0, 59) == 0) ? 1'b0 : !ioResetOut;
      validIn = 1'($urandom_range(0, 1)); dataIn = 8'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
